eq_fir_bank: RTL and testbench

- Multi-band FIR engine for the ten-band equalizer. It is the parametrised successor of the single-band FIR peripheral.
- It holds its own circular sample delay line and a coefficient RAM for each band. It runs every band over each accepted input sample, applies a Q1.15 gain per band, sums the bands with saturation, and streams out one sample.
- Configuration uses the same APB-style single-register command write with an opcode in PWData[2:0]. Status and the last result are read back on PRData.

---
 rtl/eq_fir_pkg.sv | 47 ++++
 rtl/eq_fir_sdp_ram.sv | 28 ++
 rtl/eq_fir_bank.sv | 259 +++++++++++++++++++++++++
 tb/tb_eq_fir_bank.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_fir_pkg.sv
// Shared definitions for the multi-band equalizer FIR engine.
//   - command opcodes carried in PWData[2:0]
//   - control state encoding
//   - PRData field positions
//   - sat_to_width: clamp a signed value to a signed w-bit range
package eq_fir_pkg;

  typedef enum logic [2:0] {
    OP_SET_TAPS   = 3'd0,
    OP_SEL_BAND   = 3'd1,
    OP_WR_COEFF   = 3'd2,
    OP_SET_GAIN   = 3'd3,
    OP_CLR_STATUS = 3'd4,
    OP_CLR_HIST   = 3'd5
  } opcode_t;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_GAIN,
    ST_DONE
  } state_t;

  localparam int unsigned PR_READY_BIT = 31;
  localparam int unsigned PR_OVF_BIT   = 30;
  localparam int unsigned PR_ERR_BIT   = 29;
  localparam int unsigned PR_BAND_LSB  = 25;
  localparam int unsigned PR_BAND_W    = 4;
  localparam int unsigned PR_Y_W       = 16;

  // Q1.15 fractional bits
  localparam int unsigned FRAC_BITS = 15;

  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/eq_fir_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// registered output (1-cycle read latency). Contents are not reset.
//   Clk              clock
//   WrEn/WrAddr/WrData  write port
//   RdAddr/RdData    read port, RdData valid the cycle after RdAddr
module eq_fir_sdp_ram
  import eq_fir_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              Clk,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [WIDTH-1:0]  RdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (WrEn) mem[WrAddr] <= WrData;
    RdData <= mem[RdAddr];
  end

endmodule

// File: rtl/eq_fir_bank.sv
// Multi-band FIR engine for the ten-band equalizer. Each accepted sample is
// filtered by every band (per-band coefficient region, shared delay line),
// scaled by a per-band Q1.15 gain, summed with saturation and streamed out.
//   Clk, Reset                  clock, synchronous active-high reset
//   PSel/PEnable/PWrite/ModuleEnable, PWData   command write (opcode in [2:0])
//   PRData                      {Ready, Ovf, Err, SelBand, 9'b0, last YOut}
//   SampleIn/SampleValid/SampleReady  input sample handshake
//   YOut/YValid                 output sample, YValid a one-cycle strobe
module eq_fir_bank
  import eq_fir_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEFF_W   = 16,
  parameter int unsigned GAIN_W    = 16,
  parameter int unsigned NUM_BANDS = 10,
  parameter int unsigned TAPS_BITS = 9,
  parameter int unsigned MAX_TAPS  = 281,
  parameter int unsigned ACC_W     = 40
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PSel,
  input  logic              PEnable,
  input  logic              PWrite,
  input  logic              ModuleEnable,
  input  logic [31:0]       PWData,
  output logic [31:0]       PRData,
  input  logic [DATA_W-1:0] SampleIn,
  input  logic              SampleValid,
  output logic              SampleReady,
  output logic [DATA_W-1:0] YOut,
  output logic              YValid
);

  localparam int unsigned BAND_W   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int unsigned DL_DEPTH = 1 << TAPS_BITS;
  localparam int unsigned CF_DEPTH = NUM_BANDS << TAPS_BITS;
  localparam int unsigned CF_AW    = BAND_W + TAPS_BITS;
  localparam int unsigned PROD_W   = DATA_W + COEFF_W;
  localparam int unsigned GPROD_W  = DATA_W + GAIN_W;
  localparam logic [TAPS_BITS-1:0]     TAPS_RESET = TAPS_BITS'(163);
  localparam logic signed [GAIN_W-1:0] GAIN_ONE   = {1'b0, {(GAIN_W-1){1'b1}}};

  state_t state, state_nxt;

  logic    bus_wr;
  opcode_t op;
  logic    accept;

  logic [TAPS_BITS-1:0]     num_taps, coeff_ptr, head, k, clr_ptr;
  logic [BAND_W-1:0]        sel_band, band;
  logic signed [GAIN_W-1:0] gain [NUM_BANDS];
  logic signed [ACC_W-1:0]  acc, sum;
  logic                     rd_valid;
  logic                     ovf_flag, err_flag;
  logic [DATA_W-1:0]        y_out;
  logic                     y_valid;

  logic                 x_we;
  logic [TAPS_BITS-1:0] x_waddr, x_raddr;
  logic [DATA_W-1:0]    x_wdata, x_rdata;
  logic                 c_we;
  logic [CF_AW-1:0]     c_waddr, c_raddr;
  logic [COEFF_W-1:0]   c_wdata, c_rdata;

  logic [TAPS_BITS-1:0] cmd_taps;
  logic [3:0]           cmd_band;
  logic                 taps_bad, band_bad;
  logic                 pwdata_unused;

  logic signed [DATA_W-1:0]  x_s;
  logic signed [COEFF_W-1:0] c_s;
  logic signed [PROD_W-1:0]  mac_prod;
  logic signed [ACC_W-1:0]   acc_shift;
  logic signed [63:0]        band_wide, sum_wide;
  logic                      band_clip, sum_clip;
  logic signed [DATA_W-1:0]  band_val;
  logic signed [GAIN_W-1:0]  gain_sel;
  logic signed [GPROD_W-1:0] gain_prod, gain_shift;

  assign bus_wr   = PSel & PEnable & PWrite & ModuleEnable;
  assign op       = opcode_t'(PWData[2:0]);
  assign accept   = (state == ST_IDLE) && SampleValid && !bus_wr;
  assign cmd_taps = PWData[8 +: TAPS_BITS];
  assign cmd_band = PWData[11:8];
  assign taps_bad = (cmd_taps == '0) || (32'(cmd_taps) > MAX_TAPS);
  assign band_bad = 32'(cmd_band) >= NUM_BANDS;
  assign pwdata_unused = ^{PWData[31:24], PWData[7:3]};

  // Datapath arithmetic
  assign x_s        = $signed(x_rdata);
  assign c_s        = $signed(c_rdata);
  assign mac_prod   = x_s * c_s;
  assign acc_shift  = acc >>> FRAC_BITS;
  assign band_wide  = sat_to_width(64'(acc_shift), DATA_W);
  assign band_clip  = band_wide != 64'(acc_shift);
  assign band_val   = band_wide[DATA_W-1:0];
  assign gain_sel   = gain[band];
  assign gain_prod  = band_val * gain_sel;
  assign gain_shift = gain_prod >>> FRAC_BITS;
  assign sum_wide   = sat_to_width(64'(sum), DATA_W);
  assign sum_clip   = sum_wide != 64'(sum);

  eq_fir_sdp_ram #(.WIDTH(DATA_W), .DEPTH(DL_DEPTH), .ADDR_W(TAPS_BITS)) u_delay (
    .Clk(Clk), .WrEn(x_we), .WrAddr(x_waddr), .WrData(x_wdata),
    .RdAddr(x_raddr), .RdData(x_rdata)
  );

  eq_fir_sdp_ram #(.WIDTH(COEFF_W), .DEPTH(CF_DEPTH), .ADDR_W(CF_AW)) u_coeff (
    .Clk(Clk), .WrEn(c_we), .WrAddr(c_waddr), .WrData(c_wdata),
    .RdAddr(c_raddr), .RdData(c_rdata)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_CLR;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLR:   if (clr_ptr == '1) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (bus_wr && (op == OP_CLR_HIST)) state_nxt = ST_CLR;
        else if (accept)                   state_nxt = ST_MAC;
      end
      ST_MAC:   if (k == num_taps - TAPS_BITS'(1)) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_GAIN;
      ST_GAIN:  state_nxt = (band == BAND_W'(NUM_BANDS - 1)) ? ST_DONE : ST_MAC;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_CLR;
    endcase
  end

  // Output / RAM-port control
  always_comb begin
    SampleReady = 1'b0;
    x_we        = 1'b0;
    x_waddr     = head + TAPS_BITS'(1);
    x_wdata     = SampleIn;
    x_raddr     = head - k;
    c_we        = 1'b0;
    c_waddr     = {sel_band, coeff_ptr};
    c_wdata     = PWData[8 +: COEFF_W];
    c_raddr     = {band, k};
    case (state)
      ST_CLR: begin
        x_we    = 1'b1;
        x_waddr = clr_ptr;
        x_wdata = '0;
      end
      ST_IDLE: begin
        SampleReady = !bus_wr;
        x_we        = accept;
        c_we        = bus_wr && (op == OP_WR_COEFF);
      end
      default: ;
    endcase
  end

  // Datapath and configuration registers. The RAM read for tap k lands one
  // cycle later, so rd_valid (state was MAC last cycle) gates accumulation;
  // DRAIN picks up the final product.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      num_taps  <= TAPS_RESET;
      sel_band  <= '0;
      coeff_ptr <= '0;
      head      <= '0;
      k         <= '0;
      band      <= '0;
      clr_ptr   <= '0;
      acc       <= '0;
      sum       <= '0;
      rd_valid  <= 1'b0;
      ovf_flag  <= 1'b0;
      err_flag  <= 1'b0;
      y_out     <= '0;
      y_valid   <= 1'b0;
      for (int unsigned i = 0; i < NUM_BANDS; i++) gain[i] <= GAIN_ONE;
    end else begin
      y_valid  <= 1'b0;
      rd_valid <= (state == ST_MAC);
      if (rd_valid) acc <= acc + ACC_W'(mac_prod);

      case (state)
        ST_CLR: clr_ptr <= clr_ptr + TAPS_BITS'(1);
        ST_IDLE: begin
          if (bus_wr) begin
            case (op)
              OP_SET_TAPS: begin
                if (taps_bad) err_flag <= 1'b1;
                else          num_taps <= cmd_taps;
              end
              OP_SEL_BAND: begin
                if (band_bad) err_flag <= 1'b1;
                else begin
                  sel_band  <= cmd_band[BAND_W-1:0];
                  coeff_ptr <= '0;
                end
              end
              OP_WR_COEFF:
                coeff_ptr <= (coeff_ptr == num_taps - TAPS_BITS'(1)) ? '0
                                                                     : coeff_ptr + TAPS_BITS'(1);
              OP_SET_GAIN:   gain[sel_band] <= PWData[8 +: GAIN_W];
              OP_CLR_STATUS: begin
                ovf_flag <= 1'b0;
                err_flag <= 1'b0;
              end
              OP_CLR_HIST: begin
                head    <= '0;
                clr_ptr <= '0;
              end
              default: ;
            endcase
          end else if (SampleValid) begin
            head <= head + TAPS_BITS'(1);
            k    <= '0;
            band <= '0;
            acc  <= '0;
            sum  <= '0;
          end
        end
        ST_MAC: k <= k + TAPS_BITS'(1);
        ST_GAIN: begin
          sum  <= sum + ACC_W'(gain_shift);
          acc  <= '0;
          k    <= '0;
          band <= band + BAND_W'(1);
          if (band_clip) ovf_flag <= 1'b1;
        end
        ST_DONE: begin
          y_out   <= sum_wide[DATA_W-1:0];
          y_valid <= 1'b1;
          sum     <= '0;
          if (sum_clip) ovf_flag <= 1'b1;
        end
        default: ;
      endcase

      if (bus_wr && (state != ST_IDLE)) err_flag <= 1'b1;
    end
  end

  assign YOut   = y_out;
  assign YValid = y_valid;

  always_comb begin
    PRData                              = '0;
    PRData[PR_READY_BIT]                = (state == ST_IDLE);
    PRData[PR_OVF_BIT]                  = ovf_flag;
    PRData[PR_ERR_BIT]                  = err_flag;
    PRData[PR_BAND_LSB +: PR_BAND_W]    = PR_BAND_W'(sel_band);
    PRData[PR_Y_W-1:0]                  = PR_Y_W'(y_out);
  end

endmodule

// File: tb/tb_eq_fir_bank.sv
// Directed bench for eq_fir_bank: reset/clear timing, command decode and
// error flags, impulse responses with latency, busy-write rejection,
// saturation, coefficient pointer wrap, command/sample collision and
// reset during MAC.
module tb_eq_fir_bank;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PSel = 1'b0, PEnable = 1'b0, PWrite = 1'b0, ModuleEnable = 1'b0;
  logic [31:0] PWData = '0;
  logic [31:0] PRData;
  logic [15:0] SampleIn = '0;
  logic        SampleValid = 1'b0;
  logic        SampleReady;
  logic [15:0] YOut;
  logic        YValid;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  eq_fir_bank #(
    .DATA_W(16), .COEFF_W(16), .GAIN_W(16), .NUM_BANDS(10),
    .TAPS_BITS(9), .MAX_TAPS(281), .ACC_W(40)
  ) dut (
    .Clk(Clk), .Reset(Reset), .PSel(PSel), .PEnable(PEnable), .PWrite(PWrite),
    .ModuleEnable(ModuleEnable), .PWData(PWData), .PRData(PRData),
    .SampleIn(SampleIn), .SampleValid(SampleValid), .SampleReady(SampleReady),
    .YOut(YOut), .YValid(YValid)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] sample;
    int          busy_at;   // cycles after accept to issue a SET_GAIN, -1 = none
    logic [15:0] exp_y;
    int          exp_lat;   // cycles from accept cycle to YValid cycle
  } vec_t;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] exp_pr;
  } cmd_t;

  vec_t vecs [12];
  cmd_t cmds [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [15:0] arg);
    return {8'h00, arg, 5'b00000, op};
  endfunction

  task automatic bus_write(input logic [31:0] w);
    PSel = 1'b1; PEnable = 1'b1; PWrite = 1'b1; PWData = w;
    tick();
    PSel = 1'b0; PEnable = 1'b0; PWrite = 1'b0; PWData = '0;
  endtask

  task automatic sel(input int b);
    bus_write(mk(3'd1, 16'(b)));
  endtask

  task automatic wc(input logic [15:0] v);
    bus_write(mk(3'd2, v));
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!PRData[31] && n < 2000) begin
      tick();
      n++;
    end
    check(name, 32'(PRData[31]), 32'd1);
  endtask

  // 512 clear cycles: not ready, no sample accepted, no output strobe.
  task automatic clr_check(input string name);
    int bad = 0;
    int yv  = 0;
    for (int i = 0; i < 512; i++) begin
      if (PRData[31] || SampleReady) bad++;
      if (YValid) yv++;
      tick();
    end
    check({name, "_busy"}, 32'(bad), 32'd0);
    check({name, "_yvalid"}, 32'(yv), 32'd0);
    check({name, "_prdata"}, PRData, 32'h8000_0000);
  endtask

  task automatic send_sample(input logic [15:0] s, input int busy_at,
                             output logic [15:0] y, output int lat);
    int t0;
    int n;
    SampleIn = s;
    SampleValid = 1'b1;
    n = 0;
    while (!SampleReady && n < 2000) begin
      tick();
      n++;
    end
    t0 = cyc;
    tick();
    SampleValid = 1'b0;
    SampleIn = '0;
    if (busy_at >= 0) begin
      repeat (busy_at) tick();
      bus_write(mk(3'd3, 16'h1000));
    end
    y = 16'h0;
    lat = -1;
    n = 0;
    while (!YValid && n < 4000) begin
      tick();
      n++;
    end
    if (YValid) begin
      y = YOut;
      lat = cyc - t0;
      tick();
      check("yvalid_pulse", 32'(YValid), 32'd0);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic [15:0] y;
    int lat;
    for (int i = lo; i <= hi; i++) begin
      send_sample(vecs[i].sample, vecs[i].busy_at, y, lat);
      check($sformatf("yout[%0d]", i), 32'(y), 32'(vecs[i].exp_y));
      check($sformatf("latency[%0d]", i), lat, vecs[i].exp_lat);
    end
  endtask

  initial begin
    // Impulse, 4 taps, band0 = {0x4000,0x2000,0,0}, 10 bands -> 10*6+2
    vecs[0]  = '{16'h7FFF, -1, 16'h3FFE, 62};
    vecs[1]  = '{16'h0000, -1, 16'h1FFE, 62};
    vecs[2]  = '{16'h0000, -1, 16'h0000, 62};
    vecs[3]  = '{16'h0000, -1, 16'h0000, 62};
    // Same impulse with a rejected SET_GAIN during MAC of the first sample
    vecs[4]  = '{16'h7FFF,  2, 16'h3FFE, 62};
    vecs[5]  = '{16'h0000, -1, 16'h1FFE, 62};
    vecs[6]  = '{16'h0000, -1, 16'h0000, 62};
    vecs[7]  = '{16'h0000, -1, 16'h0000, 62};
    // Two full-scale bands, 1 tap: 2*32765 clips -> 10*3+2
    vecs[8]  = '{16'h7FFF, -1, 16'h7FFF, 32};
    // Band2 after pointer wrap = {0x0400,0x0200,0x0300}, 3 taps -> 10*5+2
    vecs[9]  = '{16'h7FFF, -1, 16'h03FE, 52};
    vecs[10] = '{16'h0000, -1, 16'h01FE, 52};
    vecs[11] = '{16'h0000, -1, 16'h02FE, 52};

    cmds[0] = '{mk(3'd0, 16'd0),   32'hA000_0000};  // zero taps -> Err
    cmds[1] = '{mk(3'd4, 16'd0),   32'h8000_0000};
    cmds[2] = '{mk(3'd0, 16'd282), 32'hA000_0000};  // above MAX_TAPS -> Err
    cmds[3] = '{mk(3'd4, 16'd0),   32'h8000_0000};
    cmds[4] = '{mk(3'd1, 16'd10),  32'hA000_0000};  // band 10 -> Err, SelBand kept
    cmds[5] = '{mk(3'd4, 16'd0),   32'h8000_0000};
    cmds[6] = '{mk(3'd1, 16'd9),   32'h9200_0000};  // SelBand 9
    cmds[7] = '{mk(3'd0, 16'd281), 32'h9200_0000};  // MAX_TAPS accepted
    cmds[8] = '{mk(3'd1, 16'd0),   32'h8000_0000};

    ModuleEnable = 1'b1;
    Reset = 1'b1;
    repeat (3) tick();
    check("reset_sample_ready", 32'(SampleReady), 32'd0);
    check("reset_yvalid", 32'(YValid), 32'd0);
    Reset = 1'b0;
    clr_check("reset_clr");

    for (int i = 0; i < 9; i++) begin
      bus_write(cmds[i].cmd);
      check($sformatf("cmd[%0d]", i), PRData, cmds[i].exp_pr);
    end

    // Impulse response
    bus_write(mk(3'd0, 16'd4));
    for (int b = 1; b < 10; b++) begin
      sel(b);
      repeat (4) wc(16'h0000);
    end
    sel(0);
    wc(16'h4000); wc(16'h2000); wc(16'h0000); wc(16'h0000);
    bus_write(mk(3'd3, 16'h7FFF));
    bus_write(mk(3'd5, 16'd0));
    check("clr_hist_busy", 32'(PRData[31]), 32'd0);
    wait_ready("clr_hist_ready");
    run_vecs(0, 3);

    // Busy write
    bus_write(mk(3'd5, 16'd0));
    wait_ready("busy_clr_ready");
    run_vecs(4, 7);
    check("busy_err", 32'(PRData[29]), 32'd1);
    bus_write(mk(3'd4, 16'd0));
    check("busy_err_clr", 32'(PRData[29]), 32'd0);

    // Saturation
    bus_write(mk(3'd0, 16'd1));
    sel(0); wc(16'h7FFF);
    sel(1); wc(16'h7FFF);
    bus_write(mk(3'd3, 16'h7FFF));
    run_vecs(8, 8);
    check("ovf_set", 32'(PRData[30]), 32'd1);
    check("prdata_yout", 32'(PRData[15:0]), 32'h0000_7FFF);
    bus_write(mk(3'd4, 16'd0));
    check("ovf_clr", 32'(PRData[30]), 32'd0);

    // Coefficient pointer wrap
    bus_write(mk(3'd0, 16'd3));
    for (int b = 0; b < 10; b++) begin
      if (b != 2) begin
        sel(b);
        repeat (3) wc(16'h0000);
      end
    end
    sel(2);
    wc(16'h0100); wc(16'h0200); wc(16'h0300); wc(16'h0400);
    bus_write(mk(3'd5, 16'd0));
    wait_ready("wrap_clr_ready");
    run_vecs(9, 11);

    // Command and sample in the same IDLE cycle
    SampleIn = 16'h7FFF;
    SampleValid = 1'b1;
    PSel = 1'b1; PEnable = 1'b1; PWrite = 1'b1; PWData = mk(3'd1, 16'd3);
    #1;
    check("collide_ready_low", 32'(SampleReady), 32'd0);
    @(posedge Clk);
    #1;
    PSel = 1'b0; PEnable = 1'b0; PWrite = 1'b0; PWData = '0;
    #1;
    check("collide_cmd_done", 32'(PRData[28:25]), 32'd3);
    check("collide_still_idle", 32'(PRData[31]), 32'd1);
    check("collide_ready_next", 32'(SampleReady), 32'd1);
    tick();
    SampleValid = 1'b0;
    SampleIn = '0;
    check("collide_accepted", 32'(PRData[31]), 32'd0);

    // Reset in the middle of MAC
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    clr_check("abort_clr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
